// File: rtl/qk_inst_sequencer_if.sv
// Handshake bundle between the QK instruction sequencer and the host/fullchip side.
// The sequencer takes the master modport and drives inst/busy/done/phase.
interface qk_inst_sequencer_if;
  logic        start;
  logic        ofifo_valid;
  logic [16:0] inst;
  logic        busy;
  logic        done;
  logic [2:0]  phase;

  modport master (
    input  start,
    input  ofifo_valid,
    output inst,
    output busy,
    output done,
    output phase
  );

  modport slave (
    output start,
    output ofifo_valid,
    input  inst,
    input  busy,
    input  done,
    input  phase
  );
endinterface

// File: rtl/qk_inst_sequencer.sv
// Autonomous LOAD -> GAP1 -> EXEC -> GAP2 -> DRAIN -> DONE instruction sequencer for fullchip_gated.
// Every output is a flop; inst_q holds the word for the cycle that state_q is in.
module qk_inst_sequencer #(
  parameter logic [7:0] total_cycle = 8'd8,
  parameter logic [7:0] col         = 8'd8,
  parameter logic [9:0] gap         = 10'd10
) (
  input  logic                 clk,
  input  logic                 reset,
  qk_inst_sequencer_if.master  seq
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    GAP1  = 3'd2,
    EXEC  = 3'd3,
    GAP2  = 3'd4,
    DRAIN = 3'd5,
    DONE  = 3'd6
  } state_e;

  typedef struct packed {
    logic       ofifo_rd;
    logic [3:0] qkmem_add;
    logic [3:0] pmem_add;
    logic       execute;
    logic       load;
    logic       qmem_rd;
    logic       qmem_wr;
    logic       kmem_rd;
    logic       kmem_wr;
    logic       pmem_rd;
    logic       pmem_wr;
  } inst_t;

  localparam logic [4:0] LOAD_LAST  = 5'(col + 8'd1);
  localparam logic [4:0] COL_IDX    = 5'(col);
  localparam logic [4:0] EXEC_LAST  = 5'(total_cycle);
  localparam logic [4:0] DRAIN_WORDS = 5'(total_cycle);
  localparam logic [7:0] GAP_LAST   = 8'(gap - 10'd1);

  state_e     state_q, state_d;
  logic [4:0] idx_q,   idx_d;
  logic [7:0] gap_q,   gap_d;
  logic [4:0] n_q,     n_d;
  inst_t      inst_q,  inst_d;
  logic [4:0] n_inc;

  // Next state and counters. The word issued in a DRAIN cycle is inst_q, so
  // the word count advances only when that word actually carried a write.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    n_d     = n_q;
    n_inc   = n_q + 5'd1;

    unique case (state_q)
      IDLE: begin
        if (seq.start) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: begin
        if (idx_q == LOAD_LAST) begin
          state_d = GAP1;
          gap_d   = '0;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      GAP1: begin
        if (gap_q == GAP_LAST) begin
          state_d = EXEC;
          idx_d   = '0;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      EXEC: begin
        if (idx_q == EXEC_LAST) begin
          state_d = GAP2;
          gap_d   = '0;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      GAP2: begin
        if (gap_q == GAP_LAST) begin
          state_d = DRAIN;
          n_d     = '0;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      DRAIN: begin
        if (inst_q.ofifo_rd) begin
          n_d = n_inc;
          if (n_inc == DRAIN_WORDS) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Word for the upcoming cycle, derived from where the FSM is going. In
  // DRAIN the read/write decision uses ofifo_valid sampled at the opening edge.
  always_comb begin
    inst_d = '0;
    unique case (state_d)
      LOAD: begin
        inst_d.load    = 1'b1;
        inst_d.kmem_rd = (idx_d >= 5'd1) && (idx_d <= COL_IDX);
        if ((idx_d >= 5'd2) && (idx_d <= COL_IDX)) begin
          inst_d.qkmem_add = 4'(idx_d - 5'd1);
        end
      end
      EXEC: begin
        inst_d.execute   = 1'b1;
        inst_d.qmem_rd   = 1'b1;
        inst_d.qkmem_add = idx_d[3:0];
      end
      DRAIN: begin
        if (seq.ofifo_valid) begin
          inst_d.ofifo_rd = 1'b1;
          inst_d.pmem_wr  = 1'b1;
          inst_d.pmem_add = n_d[3:0];
        end
      end
      default: inst_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      n_q     <= '0;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      n_q     <= n_d;
      inst_q  <= inst_d;
    end
  end

  assign seq.inst  = inst_q;
  assign seq.busy  = (state_q != IDLE);
  assign seq.done  = (state_q == DONE);
  assign seq.phase = state_q;

endmodule

// File: tb/tb_qk_inst_sequencer.sv
// Scoreboard bench for qk_inst_sequencer: default-parameter DUT plus a corner-parameter DUT.
// Expected words are queued per run; monitors pop and compare on every busy cycle.
module tb_qk_inst_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  qk_inst_sequencer_if ifa ();
  qk_inst_sequencer_if ifb ();

  qk_inst_sequencer dut_a (
    .clk   (clk),
    .reset (reset),
    .seq   (ifa)
  );

  qk_inst_sequencer #(
    .total_cycle (8'd1),
    .col         (8'd1),
    .gap         (10'd1)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .seq   (ifb)
  );

  typedef struct packed {
    logic [16:0] inst;
    logic [2:0]  phase;
    logic        done;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   done_cnt_a = 0;
  int   done_cnt_b = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Bit layout: [16]ofifo_rd [15:12]qkmem_add [11:8]pmem_add [7]execute [6]load
  // [5]qmem_rd [4]qmem_wr [3]kmem_rd [2]kmem_wr [1]pmem_rd [0]pmem_wr
  function automatic logic [16:0] w_load(input int qk, input bit krd);
    return {1'b0, 4'(qk), 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, krd, 3'b000};
  endfunction

  function automatic logic [16:0] w_exec(input int qk);
    return {1'b0, 4'(qk), 4'd0, 1'b1, 1'b0, 1'b1, 5'b00000};
  endfunction

  function automatic logic [16:0] w_drain(input int pm);
    return {1'b1, 4'd0, 4'(pm), 7'b0000000, 1'b1};
  endfunction

  task automatic push(input int sel, input logic [16:0] w, input logic [2:0] ph, input logic d);
    exp_t e;
    e = '{inst: w, phase: ph, done: d};
    if (sel == 0) q_a.push_back(e);
    else          q_b.push_back(e);
  endtask

  // Queue one full run; sa/sb are absolute cycle numbers (first LOAD = 1) of DRAIN stalls.
  task automatic push_run(input int sel, input int ncol, input int tc, input int ngap,
                          input int sa, input int sb);
    int c;
    int n;
    c = 0;
    for (int i = 0; i <= ncol + 1; i++) begin
      c++;
      push(sel, w_load((i >= 2 && i <= ncol) ? i - 1 : 0, (i >= 1 && i <= ncol)), 3'd1, 1'b0);
    end
    for (int i = 0; i < ngap; i++) begin c++; push(sel, 17'd0, 3'd2, 1'b0); end
    for (int i = 0; i <= tc; i++)  begin c++; push(sel, w_exec(i), 3'd3, 1'b0); end
    for (int i = 0; i < ngap; i++) begin c++; push(sel, 17'd0, 3'd4, 1'b0); end
    n = 0;
    while (n < tc) begin
      c++;
      if (c == sa || c == sb) push(sel, 17'd0, 3'd5, 1'b0);
      else begin
        push(sel, w_drain(n), 3'd5, 1'b0);
        n++;
      end
    end
    push(sel, 17'd0, 3'd6, 1'b1);
  endtask

  exp_t ea, eb;
  always @(negedge clk) begin
    if (ifa.busy) begin
      if (q_a.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL a_extra_output: busy with nothing expected, inst=%h phase=%0d", ifa.inst, ifa.phase);
      end else begin
        ea = q_a.pop_front();
        check("a_inst",  32'(ifa.inst),  32'(ea.inst));
        check("a_phase", 32'(ifa.phase), 32'(ea.phase));
        check("a_done",  32'(ifa.done),  32'(ea.done));
      end
    end
    if (ifa.done) done_cnt_a++;
  end

  always @(negedge clk) begin
    if (ifb.busy) begin
      if (q_b.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL b_extra_output: busy with nothing expected, inst=%h phase=%0d", ifb.inst, ifb.phase);
      end else begin
        eb = q_b.pop_front();
        check("b_inst",  32'(ifb.inst),  32'(eb.inst));
        check("b_phase", 32'(ifb.phase), 32'(eb.phase));
        check("b_done",  32'(ifb.done),  32'(eb.done));
      end
    end
    if (ifb.done) done_cnt_b++;
  end

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) ifa.start = v;
    else          ifb.start = v;
  endtask

  task automatic set_ofv(input int sel, input logic v);
    if (sel == 0) ifa.ofifo_valid = v;
    else          ifb.ofifo_valid = v;
  endtask

  function automatic logic get_done(input int sel);
    return (sel == 0) ? ifa.done : ifb.done;
  endfunction

  task automatic check_idle(input int sel, input string tag);
    if (sel == 0) begin
      check({tag, "_inst"},  32'(ifa.inst),  32'd0);
      check({tag, "_busy"},  32'(ifa.busy),  32'd0);
      check({tag, "_done"},  32'(ifa.done),  32'd0);
      check({tag, "_phase"}, 32'(ifa.phase), 32'd0);
    end else begin
      check({tag, "_inst"},  32'(ifb.inst),  32'd0);
      check({tag, "_busy"},  32'(ifb.busy),  32'd0);
      check({tag, "_done"},  32'(ifb.done),  32'd0);
      check({tag, "_phase"}, 32'(ifb.phase), 32'd0);
    end
  endtask

  // One start pulse, then cycle-by-cycle drive. ofifo_valid set during cycle c
  // is sampled at the edge that opens cycle c+1. Start pulses s1..s3 and a reset
  // in cycle rst_c are held through that cycle. Returns the cycle where done was seen.
  task automatic run(input int sel, input int sa, input int sb, input int s1, input int s2,
                     input int s3, input int rst_c, output int done_cyc);
    done_cyc = -1;
    @(negedge clk);
    set_start(sel, 1'b1);
    @(posedge clk); #1;
    set_start(sel, 1'b0);
    for (int c = 1; c <= 300; c++) begin
      set_ofv(sel, !((c + 1) == sa || (c + 1) == sb));
      set_start(sel, (c == s1) || (c == s2) || (c == s3));
      if (c == rst_c) reset = 1'b1;
      @(negedge clk);
      if (c == rst_c) break;
      if (get_done(sel)) begin
        done_cyc = c;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    set_start(sel, 1'b0);
    set_ofv(sel, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int dc;
    int d0;
    reset = 1'b1;
    ifa.start = 1'b0; ifa.ofifo_valid = 1'b1;
    ifb.start = 1'b0; ifb.ofifo_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_idle(0, "a_reset");
    check_idle(1, "b_reset");

    // Reset and start together: reset wins.
    @(negedge clk);
    reset = 1'b1;
    ifa.start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    ifa.start = 1'b0;
    check_idle(0, "a_rst_vs_start");

    // Default run, no stalls.
    push_run(0, 8, 8, 10, 0, 0);
    run(0, 0, 0, 0, 0, 0, 0, dc);
    check("a_default_done_cycle", 32'(dc), 32'd48);
    check("a_default_leftover", 32'(q_a.size()), 32'd0);
    check_idle(0, "a_default_after");

    // DRAIN stalls in the 2nd and 5th DRAIN cycles (cycles 41 and 44).
    push_run(0, 8, 8, 10, 41, 44);
    run(0, 41, 44, 0, 0, 0, 0, dc);
    check("a_stall_done_cycle", 32'(dc), 32'd50);
    check("a_stall_leftover", 32'(q_a.size()), 32'd0);

    // Reset in EXEC cycle 24, then replay.
    push_run(0, 8, 8, 10, 0, 0);
    run(0, 0, 0, 0, 0, 0, 24, dc);
    check_idle(0, "a_midreset");
    check("a_midreset_remaining", 32'(q_a.size()), 32'd24);
    q_a.delete();
    push_run(0, 8, 8, 10, 0, 0);
    run(0, 0, 0, 0, 0, 0, 0, dc);
    check("a_replay_done_cycle", 32'(dc), 32'd48);
    check("a_replay_leftover", 32'(q_a.size()), 32'd0);

    // Start pulses in LOAD (3), GAP2 (32) and DONE (48) are ignored.
    d0 = done_cnt_a;
    push_run(0, 8, 8, 10, 0, 0);
    run(0, 0, 0, 3, 32, 48, 0, dc);
    check("a_busy_start_done_cycle", 32'(dc), 32'd48);
    check("a_busy_start_done_pulses", 32'(done_cnt_a - d0), 32'd1);
    check_idle(0, "a_start_in_done");
    @(posedge clk); #1;
    check("a_stays_idle", 32'(ifa.busy), 32'd0);

    // Parameter corners on the second instance.
    push_run(1, 1, 1, 1, 0, 0);
    run(1, 0, 0, 0, 0, 0, 0, dc);
    check("b_corner_done_cycle", 32'(dc), 32'd9);
    check("b_corner_leftover", 32'(q_b.size()), 32'd0);
    check("b_corner_done_pulses", 32'(done_cnt_b), 32'd1);
    check_idle(1, "b_corner_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qk_inst_sequencer.md
# qk_inst_sequencer

Autonomous instruction sequencer for `fullchip_gated`. It drives the 17-bit `inst` bus through three phases: the K-load phase, the Q·K execute phase, and the output-FIFO-to-psum-memory drain phase. Q and K memories are written beforehand by the host. It replaces host-side cycle-by-cycle instruction generation: the host issues one `start` pulse and waits for `done`.

## Interface
- `total_cycle`, 8: number of Q vectors streamed in the execute phase. Legal range 1..15.
- `col`, 8: number of K vectors loaded, one per PE column. Legal range 1..15.
- `gap`, 10: idle cycles with `inst`=0 between phases. Legal range 1..255.

Ports (one clock; reset is synchronous, active-high):
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  sampled in IDLE only; ignored otherwise.
- `ofifo_valid`  in  1  output FIFO holds a word; drain handshake.
- `inst`  out  17  registered instruction word to `fullchip_gated`. Field layout:
  - [16] ofifo_rd
  - [15:12] qkmem_add
  - [11:8] pmem_add
  - [7] execute
  - [6] load
  - [5] qmem_rd
  - [4] qmem_wr
  - [3] kmem_rd
  - [2] kmem_wr
  - [1] pmem_rd
  - [0] pmem_wr
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse in the DONE state.
- `phase`  out  3  state code: IDLE=0, LOAD=1, GAP1=2, EXEC=3, GAP2=4, DRAIN=5, DONE=6.

## Operation
- **Reset.** Next edge forces the state to IDLE and clears all counters. Outputs: `inst`=0, `busy`=0, `done`=0, `phase`=0. This applies equally to a reset asserted mid-operation: no partial phase completes.
- **IDLE.** `inst`=0. When `start`=1 at an edge, go to LOAD with index i=0.
- **LOAD.** Lasts col+2 cycles, i=0..col+1.
  - load=1 for all i.
  - kmem_rd=1 for i=1..col.
  - qkmem_add = 0 for i=0 and i=1, i-1 for i=2..col, and 0 for i=col+1.
  - Every other field is 0.
- **GAP1.** `gap` cycles with `inst`=0, then EXEC.
- **EXEC.** Lasts total_cycle+1 cycles, i=0..total_cycle.
  - execute=1 and qmem_rd=1 for all i.
  - qkmem_add = i[3:0].
  - Every other field is 0.
- **GAP2.** `gap` cycles with `inst`=0, then DRAIN.
- **DRAIN.** Moves total_cycle words; a word-count register n starts at 0.
  - In any cycle with `ofifo_valid`=1: ofifo_rd=1, pmem_wr=1, pmem_add=n, and n increments at the end of the cycle.
  - In any cycle with `ofifo_valid`=0: `inst`=0 and n is held (stall, no timeout).
  - After the cycle in which n reaches total_cycle, go to DONE.
- **DONE.** One cycle with `inst`=0, `busy`=1, `done`=1; then IDLE.
- **Arithmetic.** Address fields are 4-bit unsigned. Counters are wide enough for their maximum values (i up to 16, gap counter up to 255). Address fields never wrap within the legal parameter ranges.

## Timing
- All outputs are registered. If `start` is sampled at edge E0, the first LOAD word is visible from E0 until E1.
- With `ofifo_valid` held high, total busy time is (col+2) + gap + (total_cycle+1) + gap + total_cycle + 1 cycles. With default parameters that is 48 cycles, numbering the first LOAD cycle as 1:
  - LOAD: cycles 1–10
  - GAP1: cycles 11–20
  - EXEC: cycles 21–29
  - GAP2: cycles 30–39
  - DRAIN: cycles 40–47
  - DONE: cycle 48
- Each DRAIN stall cycle adds exactly 1 cycle to that total.
- `start` arriving in the DONE cycle is ignored. A `start` sampled on the first IDLE cycle after DONE begins a new run.
- If `reset` and `start` are both high at the same edge, reset wins: the state stays IDLE.

## Test plan
- **Default run, no stalls.**
  - Stimulus: reset, then one `start` pulse, `ofifo_valid`=1 throughout.
  - Required: `inst` sequence exactly as in Operation. LOAD qkmem_add sequence is 0,0,1,2,3,4,5,6,7,0 with kmem_rd high in cycles 2–9. EXEC qkmem_add sequence is 0..8. DRAIN pmem_add sequence is 0..7. `done` high in cycle 48 only.
- **Drain stalls.**
  - Stimulus: `ofifo_valid` low in the 2nd and 5th DRAIN cycles.
  - Required: `inst`=0 in those cycles and pmem_add held. The 8 writes carry addresses 0..7. `done` arrives in cycle 50.
- **Reset mid-EXEC.**
  - Stimulus: assert `reset` for one cycle in EXEC cycle 24.
  - Required: next cycle `inst`=0, `busy`=0, `phase`=0. A later `start` replays the full sequence from LOAD i=0.
- **Start while busy.**
  - Stimulus: pulse `start` in LOAD, in GAP2, and in DONE.
  - Required: no effect on the sequence; exactly one `done` pulse.
- **Parameter corners.**
  - Stimulus: col=1, total_cycle=1, gap=1.
  - Required: LOAD is 3 cycles with qkmem_add 0,0,0. EXEC is 2 cycles with qkmem_add 0,1. One DRAIN write at pmem_add 0. `done` in cycle 9.
- **End-to-end with `fullchip_gated`.**
  - Stimulus: Q and K memories preloaded from qdata/kdata, then a single `start`; after `done`, read pmem rows 0..7.
  - Required: each row equals the per-column dot products of Q[t] and K[q], truncated to bw_psum bits each (`bw_psum`, parameter of `fullchip_gated`). Zero mismatches.
